// File: rtl/mem_stage.sv
// MEM stage: EX/MEM pipeline register, data-memory handshake FSM, MEM/WB
// pipeline register and the pipeline stall raised while an access is pending.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog (bus_err).
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic [3:0]        ex_ctrl,
  output logic              stall,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic [REG_W-1:0]  exmem_write_reg,
  output logic              exmem_regwrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              memwb_regwrite,
  output logic [REG_W-1:0]  memwb_write_reg,
  output logic [DATA_W-1:0] memwb_write_data,
  output logic              align_err,
  output logic              bus_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  // ctrl bit positions: {regwrite, memtoreg, memread, memwrite}
  localparam int C_RW = 3, C_M2R = 2, C_MR = 1, C_MW = 0;

  logic [0:0]        state_q, state_d;
  logic              em_valid_q;
  logic [3:0]        em_ctrl_q;
  logic [DATA_W-1:0] em_alu_q, em_wdata_q;
  logic [REG_W-1:0]  em_reg_q;
  logic              mw_regwrite_q, mw_memtoreg_q;
  logic [REG_W-1:0]  mw_reg_q;
  logic [DATA_W-1:0] mw_alu_q, mw_rdata_q;

  logic access, mem_op, misalign, ex_aligned_mem, timeout_hit, advance;

  assign access   = (state_q == S_ACCESS);
  assign mem_op   = em_valid_q && (em_ctrl_q[C_MR] || em_ctrl_q[C_MW]);
  assign misalign = mem_op && (em_alu_q[1:0] != 2'b00);
  assign ex_aligned_mem = ex_valid && (ex_ctrl[C_MR] || ex_ctrl[C_MW]) &&
                          (ex_alu_result[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       bus_err_q;

  // Abort on the ACCESS cycle whose missing ack would bring the count to
  // TIMEOUT; an ack in that same cycle completes normally.
  assign timeout_hit = access && !dmem_ack && (cnt_q == 8'(TIMEOUT - 1));

  // Watchdog counter: cleared whenever the pipeline advances (covers entry
  // to ACCESS), counts every stalled ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= stall ? cnt_q + 8'd1 : 8'd0;
      bus_err_q <= timeout_hit;
    end
  end
  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  assign stall   = access && !dmem_ack && !timeout_hit;
  assign advance = !stall;

  // Next state: on any advance, ACCESS iff the op being captured is an aligned
  // memory op. An aborted access advances too, so a following memory op still
  // gets its own request instead of sitting unserviced in EX/MEM.
  always_comb begin
    state_d = state_q;
    if (advance) state_d = ex_aligned_mem ? S_ACCESS : S_IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // EX/MEM register: loads when not stalled; a bubble clears all control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      em_valid_q <= 1'b0;
      em_ctrl_q  <= '0;
      em_alu_q   <= '0;
      em_wdata_q <= '0;
      em_reg_q   <= '0;
    end else if (advance) begin
      em_valid_q <= ex_valid;
      em_ctrl_q  <= ex_valid ? ex_ctrl : 4'b0000;
      em_alu_q   <= ex_alu_result;
      em_wdata_q <= ex_store_data;
      em_reg_q   <= ex_write_reg;
    end
  end

  // MEM/WB register: writes back only completed, well-formed ops; while
  // stalled it takes a bubble so WB never sees the same op twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mw_regwrite_q <= 1'b0;
      mw_memtoreg_q <= 1'b0;
      mw_reg_q      <= '0;
      mw_alu_q      <= '0;
      mw_rdata_q    <= '0;
    end else if (advance) begin
      mw_regwrite_q <= em_valid_q && em_ctrl_q[C_RW] && !misalign && !timeout_hit;
      mw_memtoreg_q <= em_ctrl_q[C_M2R];
      mw_reg_q      <= em_reg_q;
      mw_alu_q      <= em_alu_q;
      mw_rdata_q    <= dmem_rdata;
    end else begin
      mw_regwrite_q <= 1'b0;
    end
  end

  assign exmem_alu_result = em_alu_q;
  assign exmem_write_reg  = em_reg_q;
  assign exmem_regwrite   = em_valid_q && em_ctrl_q[C_RW];

  assign dmem_req   = access;
  assign dmem_we    = access && em_ctrl_q[C_MW];
  assign dmem_addr  = access ? {em_alu_q[DATA_W-1:2], 2'b00} : '0;
  assign dmem_wdata = access ? em_wdata_q : '0;

  assign align_err = misalign;

  assign memwb_regwrite   = mw_regwrite_q;
  assign memwb_write_reg  = mw_reg_q;
  assign memwb_write_data = mw_memtoreg_q ? mw_rdata_q : mw_alu_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenario tasks plus a write-back scoreboard.
module tb_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_result, ex_store_data;
  logic [RW-1:0] ex_write_reg;
  logic [3:0]    ex_ctrl;
  logic          stall;
  logic [DW-1:0] exmem_alu_result;
  logic [RW-1:0] exmem_write_reg;
  logic          exmem_regwrite;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_write_reg;
  logic [DW-1:0] memwb_write_data;
  logic          align_err, bus_err;

  mem_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_ctrl(ex_ctrl),
    .stall(stall),
    .exmem_alu_result(exmem_alu_result), .exmem_write_reg(exmem_write_reg),
    .exmem_regwrite(exmem_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .memwb_regwrite(memwb_regwrite), .memwb_write_reg(memwb_write_reg),
    .memwb_write_data(memwb_write_data),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [RW-1:0] r; logic [DW-1:0] d; } wb_t;
  wb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Scoreboard: every register write-back must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && memwb_regwrite) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_write got r%0d=%h want none", memwb_write_reg, memwb_write_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if ({memwb_write_reg, memwb_write_data} !== {e.r, e.d}) begin
          miscompares++;
          $display("FAIL sb_writeback got r%0d=%h want r%0d=%h",
                   memwb_write_reg, memwb_write_data, e.r, e.d);
        end
      end
    end
  end

  task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] sd,
                          input logic [RW-1:0] r, input logic [3:0] c);
    ex_valid = 1'b1; ex_alu_result = a; ex_store_data = sd; ex_write_reg = r; ex_ctrl = c;
  endtask

  task automatic set_bubble();
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_write_reg = '0; ex_ctrl = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_op(32'h104, 32'h55, 5'd3, 4'b1110);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall, exmem_regwrite, dmem_req, dmem_we, memwb_regwrite, align_err, bus_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {stall, exmem_regwrite, dmem_req, dmem_we, memwb_regwrite, align_err, bus_err});
    end
    vectors++;
    if ({exmem_alu_result, dmem_addr, dmem_wdata, memwb_write_data, exmem_write_reg, memwb_write_reg} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got alu=%h addr=%h wd=%h wb=%h want all 0",
               exmem_alu_result, dmem_addr, dmem_wdata, memwb_write_data);
    end
    set_bubble(); dmem_ack = 1'b0; dmem_rdata = '0;
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_alu();
    int stalls = 0;
    drive_op(32'h10, 32'h0, 5'd8, 4'b1000);
    sb.push_back('{r: 5'd8, d: 32'h10});
    next_cycle();
    set_bubble();
    @(negedge clk);
    stalls += stall;
    vectors++;
    if ({exmem_alu_result, exmem_write_reg, exmem_regwrite} !== {32'h10, 5'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL alu_exmem got %h/r%0d/%b want 00000010/r8/1",
               exmem_alu_result, exmem_write_reg, exmem_regwrite);
    end
    next_cycle();
    @(negedge clk);
    stalls += stall;
    vectors++;
    if ({memwb_regwrite, memwb_write_reg, memwb_write_data} !== {1'b1, 5'd8, 32'h10}) begin
      miscompares++;
      $display("FAIL alu_memwb got %b/r%0d/%h want 1/r8/00000010",
               memwb_regwrite, memwb_write_reg, memwb_write_data);
    end
    vectors++;
    if (stalls != 0) begin
      miscompares++;
      $display("FAIL alu_stall got %0d want 0", stalls);
    end
    next_cycle();
  endtask

  task automatic test_load();
    int reqs = 0, stalls = 0, wbs = 0, berrs = 0;
    drive_op(32'h100, 32'h0, 5'd9, 4'b1110);
    sb.push_back('{r: 5'd9, d: 32'hDEAD_BEEF});
    next_cycle();
    set_bubble();
    for (int c = 0; c < 6; c++) begin
      dmem_ack   = (c == 2);
      dmem_rdata = (c == 2) ? 32'hDEAD_BEEF : 32'h1234_5678;
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if ({dmem_we, dmem_addr} !== {1'b0, 32'h100}) begin
          miscompares++;
          $display("FAIL load_addr got we=%b addr=%h want we=0 addr=00000100", dmem_we, dmem_addr);
        end
      end
      reqs += dmem_req; stalls += stall; wbs += memwb_regwrite; berrs += bus_err;
      next_cycle();
    end
    dmem_ack = 1'b0;
    vectors++;
    if (reqs != 3) begin miscompares++; $display("FAIL load_req_cycles got %0d want 3", reqs); end
    vectors++;
    if (stalls != 2) begin miscompares++; $display("FAIL load_stall_cycles got %0d want 2", stalls); end
    vectors++;
    if (wbs != 1) begin miscompares++; $display("FAIL load_wb_count got %0d want 1", wbs); end
    vectors++;
    if (berrs != 0) begin miscompares++; $display("FAIL load_bus_err got %0d want 0", berrs); end
  endtask

  task automatic test_back_to_back();
    drive_op(32'h200, 32'hAAAA_0001, 5'd4, 4'b0001);
    next_cycle();
    drive_op(32'h204, 32'hBBBB_0002, 5'd5, 4'b0001);
    dmem_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall} !== {2'b11, 32'h200, 32'hAAAA_0001, 1'b0}) begin
      miscompares++;
      $display("FAIL st1 got req=%b we=%b addr=%h wd=%h stall=%b want 1 1 00000200 aaaa0001 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, stall);
    end
    next_cycle();
    set_bubble();
    @(negedge clk);
    vectors++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall} !== {2'b11, 32'h204, 32'hBBBB_0002, 1'b0}) begin
      miscompares++;
      $display("FAIL st2 got req=%b we=%b addr=%h wd=%h stall=%b want 1 1 00000204 bbbb0002 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, stall);
    end
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL st_idle got req=%b want 0", dmem_req); end
    next_cycle();
  endtask

  task automatic test_misaligned();
    drive_op(32'h102, 32'h0, 5'd10, 4'b1110);
    next_cycle();
    set_bubble();
    @(negedge clk);
    vectors++;
    if ({dmem_req, align_err, stall} !== 3'b010) begin
      miscompares++;
      $display("FAIL misalign_ex got req/aerr/stall=%b want 010", {dmem_req, align_err, stall});
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({dmem_req, align_err, memwb_regwrite, stall} !== 4'b0000) begin
      miscompares++;
      $display("FAIL misalign_wb got req/aerr/wb/stall=%b want 0000",
               {dmem_req, align_err, memwb_regwrite, stall});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_op(32'h300, 32'h0, 5'd12, 4'b1110);
    next_cycle();
    set_bubble();
    @(negedge clk);
    vectors++;
    if ({dmem_req, stall} !== 2'b11) begin
      miscompares++;
      $display("FAIL rmid_pre got req/stall=%b want 11", {dmem_req, stall});
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({dmem_req, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL rmid_async got req/stall=%b want 00", {dmem_req, stall});
    end
    dmem_ack = 1'b1;
    @(posedge clk); #2;
    dmem_ack = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dmem_req, stall, exmem_regwrite, memwb_regwrite, exmem_alu_result, memwb_write_data} !== '0) begin
      miscompares++;
      $display("FAIL rmid_after got req=%b stall=%b alu=%h wb=%h want all 0",
               dmem_req, stall, exmem_alu_result, memwb_write_data);
    end
    next_cycle();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int reqs = 0, stalls = 0, berrs = 0, wbs = 0;
    drive_op(32'h400, 32'h0, 5'd11, 4'b1110);
    next_cycle();
    set_bubble();
    dmem_ack = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      reqs += dmem_req; stalls += stall; berrs += bus_err; wbs += memwb_regwrite;
      next_cycle();
    end
    vectors++;
    if (reqs != 4) begin miscompares++; $display("FAIL to_req_cycles got %0d want 4", reqs); end
    vectors++;
    if (stalls != 3) begin miscompares++; $display("FAIL to_stall_cycles got %0d want 3", stalls); end
    vectors++;
    if (berrs != 1) begin miscompares++; $display("FAIL to_bus_err got %0d want 1", berrs); end
    vectors++;
    if (wbs != 0) begin miscompares++; $display("FAIL to_wb got %0d want 0", wbs); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    set_bubble();
    dmem_ack = 1'b0; dmem_rdata = '0;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) next_cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
